// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup and EX resolution signals of the branch predict unit
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            Eq;
    logic            Gt;
    logic            isBeq;
    logic            isBgt;
    logic            isUBranch;
    logic            isCall;
    logic            isRet;
    logic            ex_pred_taken;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] branchTarget;
    logic            isBranchTaken;
    logic [XLEN-1:0] branchPC;
    logic            mispredict;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    modport master (
        output f_pc, ex_valid, ex_pc, Eq, Gt, isBeq, isBgt, isUBranch,
               isCall, isRet, ex_pred_taken, op1, branchTarget,
        input  f_pred_taken, ras_top, ras_empty, isBranchTaken, branchPC,
               mispredict, br_count, mp_count
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, Eq, Gt, isBeq, isBgt, isUBranch,
               isCall, isRet, ex_pred_taken, op1, branchTarget,
        output f_pred_taken, ras_top, ras_empty, isBranchTaken, branchPC,
               mispredict, br_count, mp_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolver with 2-bit BHT, return-address stack and perf counters
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int RAS_DEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_unit_if.slave bp
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam int PW  = $clog2(RAS_DEPTH);
    localparam int CW  = $clog2(RAS_DEPTH + 1);

    logic [1:0]      bht_q [BHT_ENTRIES];
    logic [1:0]      bht_d [BHT_ENTRIES];
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, ptr_m1;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     br_q, br_d, mp_q, mp_d;

    logic [IDX-1:0]  f_idx, ex_idx;
    logic            eeq, egt, taken, mispred, cond;
    logic            do_push, do_pop, do_swap;
    logic [XLEN-1:0] ret_addr;

    // Only the word-index bits of either PC address the BHT
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.f_pc[XLEN-1:IDX+2], bp.f_pc[1:0],
                              bp.ex_pc[XLEN-1:IDX+2], bp.ex_pc[1:0]};

    assign f_idx    = bp.f_pc[IDX+1:2];
    assign ex_idx   = bp.ex_pc[IDX+1:2];
    assign eeq      = bp.isBeq & bp.Eq;
    assign egt      = bp.isBgt & bp.Gt;
    assign taken    = bp.ex_valid & (bp.isUBranch | eeq | egt);
    assign mispred  = bp.ex_valid & (taken != bp.ex_pred_taken);
    assign cond     = bp.ex_valid & (bp.isBeq | bp.isBgt);
    assign ptr_m1   = ptr_q - PW'(1);
    assign ret_addr = bp.ex_pc + XLEN'(4);

    // Call+return on an empty stack has no entry to replace, so it pushes
    assign do_push = bp.ex_valid & bp.isCall & (~bp.isRet | (cnt_q == '0));
    assign do_pop  = bp.ex_valid & bp.isRet & ~bp.isCall & (cnt_q != '0);
    assign do_swap = bp.ex_valid & bp.isCall & bp.isRet & (cnt_q != '0);

    assign bp.isBranchTaken = taken;
    assign bp.branchPC      = bp.isRet ? bp.op1 : bp.branchTarget;
    assign bp.mispredict    = mispred;
    assign bp.f_pred_taken  = bht_q[f_idx][1];
    assign bp.ras_empty     = (cnt_q == '0);
    assign bp.ras_top       = (cnt_q == '0) ? '0 : ras_q[ptr_m1];
    assign bp.br_count      = br_q;
    assign bp.mp_count      = mp_q;

    always_comb begin
        bht_d = bht_q;
        if (cond) begin
            if (taken && bht_q[ex_idx] != 2'b11)
                bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            else if (!taken && bht_q[ex_idx] != 2'b00)
                bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
        end
    end

    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            ras_d[ptr_q] = ret_addr;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CW'(1);
        end else if (do_swap) begin
            ras_d[ptr_m1] = ret_addr;
        end
    end

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (cond && br_q != 32'hFFFF_FFFF)
            br_d = br_q + 32'd1;
        if (mispred && mp_q != 32'hFFFF_FFFF)
            mp_d = mp_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            bht_q <= bht_d;
            ras_q <= ras_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            br_q  <= br_d;
            mp_q  <= mp_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.XLEN(32)) bp_if ();

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16), .RAS_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        v, beq, bgt, ub, ret, eq, gt, pred;
        logic [31:0] op1, tgt;
        logic        e_taken;
        logic [31:0] e_pc;
        logic        e_mp;
    } vec_t;

    task automatic expect_v(input string nm, input logic [31:0] e);
        sb_q.push_back('{nm, e});
    endtask

    task automatic check_v(input logic [31:0] act);
        sb_t s;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_underflow: got %h with nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic idle();
        bp_if.f_pc = '0; bp_if.ex_valid = 0; bp_if.ex_pc = '0;
        bp_if.Eq = 0; bp_if.Gt = 0; bp_if.isBeq = 0; bp_if.isBgt = 0;
        bp_if.isUBranch = 0; bp_if.isCall = 0; bp_if.isRet = 0;
        bp_if.ex_pred_taken = 0; bp_if.op1 = '0; bp_if.branchTarget = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[6];
    logic [31:0] pop_tops[4];

    initial begin
        vecs[0] = '{1,1,0,0,0,1,0,1, 32'h0, 32'h0000_0100, 1, 32'h0000_0100, 0};
        vecs[1] = '{1,1,0,0,0,0,1,0, 32'h0, 32'h0000_0200, 0, 32'h0000_0200, 0};
        vecs[2] = '{1,0,1,0,0,0,1,0, 32'h0, 32'h0000_0300, 1, 32'h0000_0300, 1};
        vecs[3] = '{1,0,0,1,1,0,0,1, 32'h1234, 32'h9999, 1, 32'h0000_1234, 0};
        vecs[4] = '{0,0,0,1,0,0,0,1, 32'h0, 32'h0000_0400, 0, 32'h0000_0400, 0};
        vecs[5] = '{1,0,0,0,0,1,1,1, 32'h0, 32'h0000_0500, 0, 32'h0000_0500, 1};
        pop_tops = '{32'h404, 32'h304, 32'h204, 32'h0};

        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        bp_if.f_pc = 32'h40;
        #1;
        expect_v("rst_f_pred", 0);   check_v({31'd0, bp_if.f_pred_taken});
        expect_v("rst_ras_empty", 1); check_v({31'd0, bp_if.ras_empty});
        expect_v("rst_ras_top", 0);  check_v(bp_if.ras_top);
        expect_v("rst_br_count", 0); check_v(bp_if.br_count);
        expect_v("rst_mp_count", 0); check_v(bp_if.mp_count);

        // Taken BEQ at 0x40 three times; pred corrected from the second cycle
        bp_if.ex_valid = 1; bp_if.ex_pc = 32'h40; bp_if.isBeq = 1; bp_if.Eq = 1;
        expect_v("beq1_taken", 1);
        expect_v("beq1_mispredict", 1);
        expect_v("beq1_collision_pred", 0);
        #1;
        check_v({31'd0, bp_if.isBranchTaken});
        check_v({31'd0, bp_if.mispredict});
        check_v({31'd0, bp_if.f_pred_taken});
        tick();
        bp_if.ex_pred_taken = 1;
        expect_v("beq2_f_pred", 1);
        expect_v("beq2_mispredict", 0);
        #1;
        check_v({31'd0, bp_if.f_pred_taken});
        check_v({31'd0, bp_if.mispredict});
        tick();
        tick();
        bp_if.ex_valid = 0;
        expect_v("beq_br_count", 3);
        expect_v("beq_mp_count", 1);
        expect_v("beq_f_pred_sat", 1);
        #1;
        check_v(bp_if.br_count);
        check_v(bp_if.mp_count);
        check_v({31'd0, bp_if.f_pred_taken});

        // Not-taken BGT twice: 11 -> 10 -> 01 proves saturation and single steps
        bp_if.ex_valid = 1; bp_if.isBeq = 0; bp_if.isBgt = 1; bp_if.Gt = 0; bp_if.Eq = 1;
        bp_if.branchTarget = 32'h80; bp_if.op1 = 32'h55; bp_if.ex_pred_taken = 1;
        expect_v("bgt_taken", 0);
        expect_v("bgt_branchPC", 32'h80);
        expect_v("bgt_mispredict", 1);
        #1;
        check_v({31'd0, bp_if.isBranchTaken});
        check_v(bp_if.branchPC);
        check_v({31'd0, bp_if.mispredict});
        tick();
        expect_v("bgt1_f_pred", 1);
        expect_v("bgt1_br_count", 4);
        expect_v("bgt1_mp_count", 2);
        check_v({31'd0, bp_if.f_pred_taken});
        check_v(bp_if.br_count);
        check_v(bp_if.mp_count);
        tick();
        bp_if.ex_valid = 0;
        expect_v("bgt2_f_pred", 0);
        expect_v("bgt2_br_count", 5);
        expect_v("bgt2_mp_count", 3);
        #1;
        check_v({31'd0, bp_if.f_pred_taken});
        check_v(bp_if.br_count);
        check_v(bp_if.mp_count);

        // Five calls into a 4-deep RAS, then five returns
        idle();
        bp_if.ex_valid = 1; bp_if.isUBranch = 1; bp_if.isCall = 1; bp_if.ex_pred_taken = 1;
        for (int i = 1; i <= 5; i++) begin
            bp_if.ex_pc = 32'(i) * 32'h100;
            expect_v($sformatf("call%0d_ras_top", i), 32'(i) * 32'h100 + 32'd4);
            expect_v($sformatf("call%0d_ras_empty", i), 0);
            tick();
            check_v(bp_if.ras_top);
            check_v({31'd0, bp_if.ras_empty});
        end
        bp_if.isCall = 0; bp_if.isRet = 1; bp_if.op1 = 32'h504; bp_if.branchTarget = 32'h9;
        expect_v("ret_taken", 1);
        expect_v("ret_branchPC", 32'h504);
        #1;
        check_v({31'd0, bp_if.isBranchTaken});
        check_v(bp_if.branchPC);
        for (int k = 0; k < 4; k++) begin
            expect_v($sformatf("pop%0d_ras_top", k + 1), pop_tops[k]);
            expect_v($sformatf("pop%0d_ras_empty", k + 1), (k == 3) ? 32'd1 : 32'd0);
            tick();
            check_v(bp_if.ras_top);
            check_v({31'd0, bp_if.ras_empty});
        end
        expect_v("pop5_ras_top", 0);
        expect_v("pop5_ras_empty", 1);
        expect_v("ras_br_count", 5);
        expect_v("ras_mp_count", 3);
        tick();
        check_v(bp_if.ras_top);
        check_v({31'd0, bp_if.ras_empty});
        check_v(bp_if.br_count);
        check_v(bp_if.mp_count);

        // Combinational resolution table at ex_pc 0x44 (BHT index 1)
        idle();
        bp_if.ex_pc = 32'h44;
        for (int i = 0; i < 6; i++) begin
            bp_if.ex_valid = vecs[i].v; bp_if.isBeq = vecs[i].beq; bp_if.isBgt = vecs[i].bgt;
            bp_if.isUBranch = vecs[i].ub; bp_if.isRet = vecs[i].ret; bp_if.Eq = vecs[i].eq;
            bp_if.Gt = vecs[i].gt; bp_if.ex_pred_taken = vecs[i].pred;
            bp_if.op1 = vecs[i].op1; bp_if.branchTarget = vecs[i].tgt;
            expect_v($sformatf("vec%0d_taken", i), {31'd0, vecs[i].e_taken});
            expect_v($sformatf("vec%0d_branchPC", i), vecs[i].e_pc);
            expect_v($sformatf("vec%0d_mispredict", i), {31'd0, vecs[i].e_mp});
            #1;
            check_v({31'd0, bp_if.isBranchTaken});
            check_v(bp_if.branchPC);
            check_v({31'd0, bp_if.mispredict});
            tick();
        end
        idle();
        bp_if.f_pc = 32'h44;
        expect_v("idx1_f_pred", 1);
        #1;
        check_v({31'd0, bp_if.f_pred_taken});

        // Reset in the middle of a valid call + taken BEQ
        bp_if.ex_valid = 1; bp_if.isCall = 1; bp_if.isUBranch = 1;
        bp_if.ex_pc = 32'h700; bp_if.isBeq = 1; bp_if.Eq = 1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        expect_v("mrst_ras_empty", 1);
        expect_v("mrst_ras_top", 0);
        expect_v("mrst_br_count", 0);
        expect_v("mrst_mp_count", 0);
        #1;
        check_v({31'd0, bp_if.ras_empty});
        check_v(bp_if.ras_top);
        check_v(bp_if.br_count);
        check_v(bp_if.mp_count);
        for (int i = 0; i < 16; i++) begin
            bp_if.f_pc = 32'(i) * 32'd4;
            expect_v($sformatf("mrst_bht%0d", i), 0);
            #1;
            check_v({31'd0, bp_if.f_pred_taken});
        end

        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
